circular_writeback_buffer: RTL
==============================

Name: circular_writeback_buffer

Overview:
- Write-side counterpart of the per-PE circular read buffer.
- Collects eight 16-bit PE result lanes per write beat into an 8x8 bank, column by column, using a circular write pointer.
- When all 8 columns are written, drains the 64 words serially over a valid/ready stream.
- Drain order and addresses match the layout the read buffer consumes: word(lane i, column j) goes to address BASE_ADDR + 8*i + j.

Parameters:
- SIZE, 8, columns per lane (depth of circular write pointer); fixed at 8 lanes x SIZE words.
- BASE_ADDR, 0, address offset added to every drained word's address.
- ADDR_W, 10, width of out_addr (1024-word result space).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-low (sampled on clk rising edge; 0 = reset).
- write_en  input  1  write beat strobe; ignored while full=1.
- write_data_1 .. write_data_8  input  16 each  lane 1..8 results for the current column.
- full  output  1  1 while draining; producer must hold off write_en.
- fill_level  output  4  number of columns written in the current frame, 0..8.
- out_valid  output  1  drain word available.
- out_ready  input  1  downstream accepts the word when out_valid & out_ready.
- out_data  output  16  drained word.
- out_addr  output  ADDR_W  BASE_ADDR + 8*lane + column of out_data.
- done  output  1  one-cycle pulse after the final (64th) word is accepted.

Behaviour:
- States: FILL, DRAIN.
- Reset (rst=0 at a clock edge) from any state, including mid-fill or mid-drain:
  - state=FILL, write_ptr=0, drain_cnt=0.
  - full=0, fill_level=0, out_valid=0, done=0, out_addr=BASE_ADDR.
  - Bank contents are not cleared; they are don't-care until rewritten.
- FILL:
  - On an edge with write_en=1, buffer[k-1][write_ptr] <= write_data_k for k=1..8.
  - On the same edge, write_ptr <= (write_ptr+1) mod SIZE and fill_level increments.
  - write_en=0 holds all state.
  - The write that moves write_ptr 7->0 (the 8th column) also moves state to DRAIN on that same edge; fill_level reads 8 from that edge.
- DRAIN:
  - full=1 and out_valid=1 from the cycle after the 8th write; first word visible one cycle after that write.
  - drain_cnt (6 bit) selects lane=drain_cnt[5:3], column=drain_cnt[2:0].
  - out_data=buffer[lane][column]; out_addr=BASE_ADDR+drain_cnt, zero-extended/truncated to ADDR_W.
  - out_data and out_addr are stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid & out_ready, drain_cnt increments.
  - On acceptance of word 63: state=FILL, drain_cnt=0, write_ptr=0, fill_level=0, full=0, out_valid=0 on that edge; done=1 for exactly the following cycle.
  - write_en=1 during DRAIN is dropped: no bank write, no pointer change.
- Simultaneous events:
  - A write_en in the first FILL cycle after the drain completes (the cycle done=1) is accepted normally into column 0.
  - out_ready while in FILL has no effect.
- Latency: 8 write beats, then 64 words with back-to-back out_ready 1. With no stalls, one frame is 8 + 64 cycles.
- Arithmetic: no arithmetic on data; pure storage. Pointer wrap is modulo 8. Address sum is unsigned.

Test Plan:
- Reset: hold rst=0 2 cycles with write_en=1 -> full=0, out_valid=0, fill_level=0, out_addr=BASE_ADDR, done=0.
- Fill and drain: BASE_ADDR=0, 8 beats with write_data_k = 16'h(k-1)(col)00 (e.g. lane 3, col 5 = 16'h2500), out_ready=1.
  - full rises the cycle after beat 8.
  - 64 words out in order 16'h0000, 16'h0100 .. 16'h0700, 16'h1000 ..; out_addr 0..63.
  - done pulses once; fill_level returns to 0.
- Backpressure: toggle out_ready 1/0 pseudo-randomly during drain -> no word lost or duplicated; out_data/out_addr held while stalled; 64 acceptances total.
- Write while full: assert write_en with 16'hFFFF on all lanes throughout drain -> drained values unchanged; fill_level stays 8 until done.
- Gapped writes and offset: BASE_ADDR=128, write_en on alternate cycles -> fill_level steps 1..8; first out_addr=128, last=191.
- Reset mid-drain: apply rst=0 after 20 accepted words -> next cycle out_valid=0, full=0. A fresh 8-beat fill then drains from out_addr=BASE_ADDR with the new data.

Source files
------------

// File: rtl/circular_writeback_buffer.sv
// Write-side circular buffer: gathers eight PE result lanes column by column,
// then streams the whole lane-major frame out over a valid/ready port.
module circular_writeback_buffer #(
    parameter int SIZE      = 8,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [15:0]       write_data_1,
    input  logic [15:0]       write_data_2,
    input  logic [15:0]       write_data_3,
    input  logic [15:0]       write_data_4,
    input  logic [15:0]       write_data_5,
    input  logic [15:0]       write_data_6,
    input  logic [15:0]       write_data_7,
    input  logic [15:0]       write_data_8,
    output logic              full,
    output logic [3:0]        fill_level,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);

    localparam int PW = $clog2(SIZE);
    localparam int CW = 3 + PW;
    localparam logic [PW-1:0] PTR_LAST = PW'(SIZE - 1);
    localparam logic [CW-1:0] CNT_LAST = '1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [3:0]    fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          wr;

    logic [15:0] bank_q [8][SIZE];
    logic [15:0] wdata [8];

    assign wdata[0] = write_data_1;
    assign wdata[1] = write_data_2;
    assign wdata[2] = write_data_3;
    assign wdata[3] = write_data_4;
    assign wdata[4] = write_data_5;
    assign wdata[5] = write_data_6;
    assign wdata[6] = write_data_7;
    assign wdata[7] = write_data_8;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr      = 1'b0;
        unique case (state_q)
            FILL: begin
                if (write_en) begin
                    wr     = 1'b1;
                    fill_d = fill_q + 4'd1;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        ptr_d   = '0;
                        fill_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            ptr_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Storage only; contents are meaningless until rewritten after reset.
    always_ff @(posedge clk) begin
        if (rst && wr) begin
            for (int k = 0; k < 8; k++) begin
                bank_q[k][ptr_q] <= wdata[k];
            end
        end
    end

    assign full       = (state_q == DRAIN);
    assign out_valid  = (state_q == DRAIN);
    assign fill_level = fill_q;
    assign done       = done_q;
    assign out_data   = bank_q[cnt_q[CW-1:PW]][cnt_q[PW-1:0]];
    assign out_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q);

endmodule
